// File: rtl/tdc_burst_reader.sv
// Burst reader for the delay-line sensor / TDC pair: launches, captures and averages thermometer codes.
// Optional macro TDC_BURST_READER_BUBBLE_FIX_EN counts only the leading run of ones as hits.
module tdc_burst_reader #(
    parameter int LOG2_N = 2,
    parameter int SETTLE = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_i,
    input  logic       clear_i,
    input  logic [7:0] code_i,
    output logic       launch_o,
    output logic       busy_o,
    output logic [3:0] result_o,
    output logic       result_valid_o,
    output logic [7:0] bubble_cnt_o
);

    localparam int ACC_W = 4 + LOG2_N;
    localparam int CNT_W = (LOG2_N > 0) ? LOG2_N : 1;
    localparam logic [CNT_W-1:0] LAST_SAMPLE = CNT_W'((1 << LOG2_N) - 1);
    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE - 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LAUNCH  = 3'd1,
        ST_WAIT    = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

`ifdef TDC_BURST_READER_BUBBLE_FIX_EN
    function automatic logic [3:0] hit_count(input logic [7:0] code);
        logic [3:0] n;
        logic       run;
        n   = 4'd0;
        run = 1'b1;
        for (int i = 0; i < 8; i++) begin
            run = run & code[i];
            n   = n + {3'd0, run};
        end
        return n;
    endfunction
`else
    function automatic logic [3:0] hit_count(input logic [7:0] code);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'd0, code[i]};
        end
        return n;
    endfunction
`endif

    // A valid code is a solid run of ones from bit0; adding one then clears every set bit.
    function automatic logic is_bubble(input logic [7:0] code);
        return (code & (code + 8'd1)) != 8'd0;
    endfunction

    state_t           state_r;
    state_t           state_next_s;
    logic [3:0]       settle_r;
    logic [CNT_W-1:0] sample_cnt_r;
    logic [ACC_W-1:0] acc_r;
    logic [ACC_W-1:0] acc_sum_s;
    logic [3:0]       hit_s;
    logic             bubble_s;
    logic             launch_r;
    logic             busy_r;
    logic             result_valid_r;
    logic [3:0]       result_r;
    logic [7:0]       bubble_cnt_r;
    logic             launch_next_s;
    logic             busy_next_s;
    logic             result_valid_next_s;

    assign hit_s     = hit_count(code_i);
    assign bubble_s  = is_bubble(code_i);
    assign acc_sum_s = acc_r + ACC_W'(hit_s);

    // State register and registered control outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r        <= ST_IDLE;
            launch_r       <= 1'b0;
            busy_r         <= 1'b0;
            result_valid_r <= 1'b0;
        end else begin
            state_r        <= state_next_s;
            launch_r       <= launch_next_s;
            busy_r         <= busy_next_s;
            result_valid_r <= result_valid_next_s;
        end
    end

    // Next-state logic; clear_i overrides everything, including a simultaneous start.
    always_comb begin
        state_next_s = state_r;
        if (clear_i) begin
            state_next_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE:    state_next_s = start_i ? ST_LAUNCH : ST_IDLE;
                ST_LAUNCH:  state_next_s = ST_WAIT;
                ST_WAIT:    state_next_s = (settle_r == 4'd0) ? ST_CAPTURE : ST_WAIT;
                ST_CAPTURE: state_next_s = (sample_cnt_r == LAST_SAMPLE) ? ST_DONE : ST_LAUNCH;
                ST_DONE:    state_next_s = ST_IDLE;
                default:    state_next_s = ST_IDLE;
            endcase
        end
    end

    // Output decode from the next state so the registered outputs line up with the state.
    always_comb begin
        launch_next_s       = 1'b0;
        busy_next_s         = 1'b0;
        result_valid_next_s = 1'b0;
        if (state_next_s == ST_LAUNCH) begin
            launch_next_s = 1'b1;
        end else begin
            launch_next_s = 1'b0;
        end
        if (state_next_s != ST_IDLE) begin
            busy_next_s = 1'b1;
        end else begin
            busy_next_s = 1'b0;
        end
        if (state_next_s == ST_DONE) begin
            result_valid_next_s = 1'b1;
        end else begin
            result_valid_next_s = 1'b0;
        end
    end

    // Datapath: settle timer, sample counter, accumulator, result and bubble counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            settle_r     <= 4'd0;
            sample_cnt_r <= '0;
            acc_r        <= '0;
            result_r     <= 4'd0;
            bubble_cnt_r <= 8'd0;
        end else if (clear_i) begin
            sample_cnt_r <= '0;
            acc_r        <= '0;
            bubble_cnt_r <= 8'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start_i) begin
                        sample_cnt_r <= '0;
                        acc_r        <= '0;
                    end
                end
                ST_LAUNCH: settle_r <= SETTLE_LOAD;
                ST_WAIT: begin
                    if (settle_r != 4'd0) begin
                        settle_r <= settle_r - 4'd1;
                    end
                end
                ST_CAPTURE: begin
                    acc_r <= acc_sum_s;
                    if (bubble_s && (bubble_cnt_r != 8'd255)) begin
                        bubble_cnt_r <= bubble_cnt_r + 8'd1;
                    end
                    // The final sum is at most 8 << LOG2_N, so the shifted value always fits 4 bits.
                    if (sample_cnt_r == LAST_SAMPLE) begin
                        result_r <= 4'(acc_sum_s >> LOG2_N);
                    end else begin
                        sample_cnt_r <= sample_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                default: ;
            endcase
        end
    end

    assign launch_o       = launch_r;
    assign busy_o         = busy_r;
    assign result_valid_o = result_valid_r;
    assign result_o       = result_r;
    assign bubble_cnt_o   = bubble_cnt_r;

endmodule

// File: tb/tb_tdc_burst_reader.sv
// Self-checking bench for tdc_burst_reader: vector table of bursts plus hand-written clear/restart/reset sequences.
module tb_tdc_burst_reader;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start_i;
    logic       clear_i;
    logic [7:0] code_i;
    logic       launch_o;
    logic       busy_o;
    logic [3:0] result_o;
    logic       result_valid_o;
    logic [7:0] bubble_cnt_o;

    tdc_burst_reader #(.LOG2_N(2), .SETTLE(3)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start_i        (start_i),
        .clear_i        (clear_i),
        .code_i         (code_i),
        .launch_o       (launch_o),
        .busy_o         (busy_o),
        .result_o       (result_o),
        .result_valid_o (result_valid_o),
        .bubble_cnt_o   (bubble_cnt_o)
    );

    always #5 clk = ~clk;

`ifdef TDC_BURST_READER_BUBBLE_FIX_EN
    localparam logic [3:0] RES_17 = 4'd3;
    localparam logic [3:0] RES_AA = 4'd0;
`else
    localparam logic [3:0] RES_17 = 4'd4;
    localparam logic [3:0] RES_AA = 4'd4;
`endif

    typedef struct {
        logic [3:0][7:0] codes;
        logic [3:0]      res;
    } vec_t;

    vec_t       vecs[8];
    logic [3:0] sb_q[$];
    int         checks = 0;
    int         errors = 0;
    int         bub_exp = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Non-monotonic if any set bit sits above a clear bit.
    function automatic int tb_bubble(input logic [7:0] c);
        bit seen_zero;
        seen_zero = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (!c[i]) seen_zero = 1'b1;
            else if (seen_zero) return 1;
        end
        return 0;
    endfunction

    task automatic run_burst(input logic [3:0][7:0] codes, input logic [3:0] exp_res, input int restart_cyc);
        int k;
        bit done;
        k    = 0;
        done = 1'b0;
        sb_q.push_back(exp_res);
        start_i = 1'b1;
        @(negedge clk);
        for (int c = 1; c <= 60 && !done; c++) begin
            if (launch_o) begin
                if (k < 4) begin
                    code_i = codes[k];
                    chk("launch_cycle", c, 1 + 5 * k);
                end
                k++;
            end
            if (result_valid_o) begin
                chk("done_cycle", c, 21);
                if (sb_q.size() == 0) chk("scoreboard_empty", 1, 0);
                else chk("result", int'(result_o), int'(sb_q.pop_front()));
                done = 1'b1;
            end
            start_i = (c == restart_cyc);
            @(negedge clk);
        end
        start_i = 1'b0;
        if (!done) begin
            chk("done_timeout", 0, 1);
            if (sb_q.size() > 0) void'(sb_q.pop_front());
        end
        chk("busy_after_done", int'(busy_o), 0);
        chk("valid_one_cycle", int'(result_valid_o), 0);
        chk("launch_count", k, 4);
        for (int i = 0; i < 4; i++) bub_exp += tb_bubble(codes[i]);
        if (bub_exp > 255) bub_exp = 255;
        chk("bubble_cnt", int'(bubble_cnt_o), bub_exp);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] prev_res;
        int         n_launch;
        int         n_valid;

        vecs[0].codes = {8'h0F, 8'h0F, 8'h0F, 8'h0F}; vecs[0].res = 4'd4;
        vecs[1].codes = {8'hFF, 8'h07, 8'h03, 8'h01}; vecs[1].res = 4'd3;
        vecs[2].codes = {8'h17, 8'h17, 8'h17, 8'h17}; vecs[2].res = RES_17;
        vecs[3].codes = {8'h00, 8'h00, 8'h00, 8'h00}; vecs[3].res = 4'd0;
        vecs[4].codes = {8'hFF, 8'hFF, 8'hFF, 8'hFF}; vecs[4].res = 4'd8;
        vecs[5].codes = {8'h7F, 8'hFF, 8'h00, 8'h01}; vecs[5].res = 4'd4;
        vecs[6].codes = {8'h3F, 8'h3F, 8'h1F, 8'h0F}; vecs[6].res = 4'd5;
        vecs[7].codes = {8'hAA, 8'hAA, 8'hAA, 8'hAA}; vecs[7].res = RES_AA;

        rst_n   = 1'b0;
        start_i = 1'b0;
        clear_i = 1'b0;
        code_i  = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_launch", int'(launch_o), 0);
        chk("rst_busy", int'(busy_o), 0);
        chk("rst_valid", int'(result_valid_o), 0);
        chk("rst_result", int'(result_o), 0);
        chk("rst_bubble", int'(bubble_cnt_o), 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 8; v++) run_burst(vecs[v].codes, vecs[v].res, 0);

        // Saturation of the bubble counter from zero.
        clear_i = 1'b1;
        @(negedge clk);
        clear_i = 1'b0;
        bub_exp = 0;
        chk("clear_bubble", int'(bubble_cnt_o), 0);
        for (int b = 0; b < 65; b++) run_burst(vecs[2].codes, RES_17, 0);
        chk("bubble_saturated", int'(bubble_cnt_o), 255);

        // Clear during the WAIT of the second sample.
        prev_res = result_o;
        start_i  = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        repeat (6) @(negedge clk);
        chk("busy_in_wait", int'(busy_o), 1);
        clear_i = 1'b1;
        @(negedge clk);
        clear_i = 1'b0;
        bub_exp = 0;
        chk("clear_busy", int'(busy_o), 0);
        chk("clear_bubble_mid", int'(bubble_cnt_o), 0);
        chk("clear_launch", int'(launch_o), 0);
        chk("clear_result_hold", int'(result_o), int'(prev_res));
        n_launch = 0;
        n_valid  = 0;
        for (int c = 0; c < 25; c++) begin
            n_launch += int'(launch_o);
            n_valid  += int'(result_valid_o);
            @(negedge clk);
        end
        chk("clear_no_valid", n_valid, 0);
        chk("clear_no_launch", n_launch, 0);

        // start together with clear: clear wins.
        start_i = 1'b1;
        clear_i = 1'b1;
        @(negedge clk);
        start_i  = 1'b0;
        clear_i  = 1'b0;
        n_launch = 0;
        for (int c = 0; c < 10; c++) begin
            n_launch += int'(launch_o) + int'(busy_o);
            @(negedge clk);
        end
        chk("start_clear_no_burst", n_launch, 0);

        // start while busy is ignored, then nothing follows the single result.
        run_burst(vecs[6].codes, vecs[6].res, 3);
        n_launch = 0;
        n_valid  = 0;
        for (int c = 0; c < 10; c++) begin
            n_launch += int'(launch_o);
            n_valid  += int'(result_valid_o);
            @(negedge clk);
        end
        chk("restart_no_launch", n_launch, 0);
        chk("restart_no_valid", n_valid, 0);

        // Asynchronous reset in the middle of CAPTURE.
        run_burst(vecs[2].codes, RES_17, 0);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        repeat (4) @(negedge clk);
        chk("capture_busy", int'(busy_o), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_busy", int'(busy_o), 0);
        chk("async_launch", int'(launch_o), 0);
        chk("async_valid", int'(result_valid_o), 0);
        chk("async_result", int'(result_o), 0);
        chk("async_bubble", int'(bubble_cnt_o), 0);
        @(negedge clk);
        rst_n   = 1'b1;
        bub_exp = 0;
        sb_q.delete();
        @(negedge clk);
        run_burst(vecs[1].codes, vecs[1].res, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
